axi4_read_arbiter: RTL and testbench

// Shares the AR/R read channels of the 128-bit AXI4 on-chip RAM between NUM_MASTERS requesters
// (DPI master, DMA, ...). Uses round-robin grant with one outstanding burst at a time.

---
 rtl/axi4_read_arbiter_pkg.sv | 45 ++++
 rtl/axi4_read_arbiter_rr.sv | 35 +++
 rtl/axi4_read_arbiter.sv | 127 ++++++++++++
 tb/tb_axi4_read_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_read_arbiter_pkg.sv
// ============================================================================
// axi4_read_arbiter_pkg : widths, FSM states and AR/R field helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package axi4_read_arbiter_pkg;

  function automatic int ar_width(input int addr_w);
    return addr_w + 13;
  endfunction

  function automatic int r_width(input int data_w);
    return data_w + 3;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Low-order fields of the packed AR {addr,len,size,burst} and R {data,resp,last} words
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } ar_tail_t;

  typedef struct packed {
    logic [1:0] resp;
    logic       last;
  } r_tail_t;

  function automatic logic [7:0] ar_len(input ar_tail_t t);
    return t.len;
  endfunction

  function automatic logic r_last(input r_tail_t t);
    return t.last;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_read_arbiter_rr.sv
// ============================================================================
// axi4_read_arbiter_rr : round-robin pick of the first requester after last_i
// Rev 1.0
// ============================================================================
`default_nettype none

module axi4_read_arbiter_rr #(
  parameter  int N    = 2,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] last_i,
  output logic [N-1:0]    grant_o,
  output logic [ID_W-1:0] grant_idx_o,
  output logic            valid_o
);

  // Walk from the farthest offset back to the nearest so the nearest request wins
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    for (int off = N; off >= 1; off--) begin
      if (req_i[(int'(last_i) + off) % N]) begin
        grant_o                             = '0;
        grant_o[(int'(last_i) + off) % N]   = 1'b1;
        grant_idx_o                         = ID_W'((int'(last_i) + off) % N);
        valid_o                             = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi4_read_arbiter.sv
// ============================================================================
// axi4_read_arbiter : shares one AXI4 RAM read port among NUM_MASTERS, one burst at a time
// Rev 1.0
// ============================================================================
`default_nettype none

module axi4_read_arbiter
  import axi4_read_arbiter_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 128,
  localparam int AR_W        = ar_width(ADDR_W),
  localparam int R_W         = r_width(DATA_W),
  localparam int ID_W        = $clog2(NUM_MASTERS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_MASTERS-1:0]      s_ar_valid,
  output logic [NUM_MASTERS-1:0]      s_ar_ready,
  input  logic [NUM_MASTERS*AR_W-1:0] s_ar_payload,
  output logic [NUM_MASTERS-1:0]      s_r_valid,
  input  logic [NUM_MASTERS-1:0]      s_r_ready,
  output logic [R_W-1:0]              s_r_payload,
  output logic                        m_ar_valid,
  input  logic                        m_ar_ready,
  output logic [AR_W-1:0]             m_ar_payload,
  input  logic                        m_r_valid,
  output logic                        m_r_ready,
  input  logic [R_W-1:0]              m_r_payload,
  output logic [ID_W-1:0]             grant_id,
  output logic                        busy,
  output logic                        len_err
);

  state_e                  state_q;
  logic [ID_W-1:0]         grant_id_q;
  logic [AR_W-1:0]         m_ar_payload_q;
  logic [7:0]              beat_cnt_q;
  logic                    m_ar_valid_q;
  logic                    busy_q;
  logic                    len_err_q;

  logic [NUM_MASTERS-1:0]  next_oh;
  logic [ID_W-1:0]         next_idx;
  logic                    next_any;
  logic [AR_W-1:0]         sel_ar;
  logic [NUM_MASTERS-1:0]  owner_oh;
  logic                    r_beat;
  logic                    r_is_last;

  axi4_read_arbiter_rr #(.N(NUM_MASTERS)) u_rr (
    .req_i       (s_ar_valid),
    .last_i      (grant_id_q),
    .grant_o     (next_oh),
    .grant_idx_o (next_idx),
    .valid_o     (next_any)
  );

  assign sel_ar    = s_ar_payload[int'(next_idx) * AR_W +: AR_W];
  assign owner_oh  = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << grant_id_q;
  assign r_is_last = r_last(r_tail_t'(m_r_payload[2:0]));
  assign r_beat    = m_r_valid && m_r_ready;

  assign s_ar_ready  = (state_q == ST_IDLE) ? next_oh : '0;
  assign s_r_valid   = (state_q == ST_DATA && m_r_valid) ? owner_oh : '0;
  assign m_r_ready   = (state_q == ST_DATA) && s_r_ready[grant_id_q];
  assign s_r_payload = m_r_payload;

  assign m_ar_valid   = m_ar_valid_q;
  assign m_ar_payload = m_ar_payload_q;
  assign grant_id     = grant_id_q;
  assign busy         = busy_q;
  assign len_err      = len_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      grant_id_q     <= ID_W'(NUM_MASTERS - 1);
      m_ar_payload_q <= '0;
      beat_cnt_q     <= '0;
      m_ar_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      len_err_q      <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (next_any) begin
            grant_id_q     <= next_idx;
            m_ar_payload_q <= sel_ar;
            beat_cnt_q     <= ar_len(ar_tail_t'(sel_ar[12:0]));
            m_ar_valid_q   <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_ar_ready) begin
            m_ar_valid_q <= 1'b0;
            state_q      <= ST_DATA;
          end
        end
        ST_DATA: begin
          // Length mismatches are flagged but only the RAM's last beat ends the burst
          if (r_beat) begin
            beat_cnt_q <= (beat_cnt_q == 8'd0) ? 8'd0 : beat_cnt_q - 8'd1;
            len_err_q  <= (r_is_last && beat_cnt_q != 8'd0) ||
                          (!r_is_last && beat_cnt_q == 8'd0);
            if (r_is_last) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          m_ar_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi4_read_arbiter.sv
// ============================================================================
// tb_axi4_read_arbiter : randomized self-checking bench with a transaction-level model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi4_read_arbiter;

  localparam int NM   = 2;
  localparam int AW   = 32;
  localparam int DW   = 128;
  localparam int AR_W = AW + 13;
  localparam int R_W  = DW + 3;
  localparam int GW   = 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NM-1:0]        s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
  logic [NM*AR_W-1:0]   s_ar_payload;
  logic [R_W-1:0]       s_r_payload, m_r_payload;
  logic                 m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [AR_W-1:0]      m_ar_payload;
  logic [GW-1:0]        grant_id;
  logic                 busy, len_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor-owned counters; tests only read them as before/after snapshots
  int beats_to[NM] = '{default: 0};
  int lenerr_cnt     = 0;
  int busy_ready_cnt = 0;
  int grants[$];

  always #5 clk = ~clk;

  axi4_read_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_ar_valid   (s_ar_valid),
    .s_ar_ready   (s_ar_ready),
    .s_ar_payload (s_ar_payload),
    .s_r_valid    (s_r_valid),
    .s_r_ready    (s_r_ready),
    .s_r_payload  (s_r_payload),
    .m_ar_valid   (m_ar_valid),
    .m_ar_ready   (m_ar_ready),
    .m_ar_payload (m_ar_payload),
    .m_r_valid    (m_r_valid),
    .m_r_ready    (m_r_ready),
    .m_r_payload  (m_r_payload),
    .grant_id     (grant_id),
    .busy         (busy),
    .len_err      (len_err)
  );

  always begin
    @(negedge clk);
    #2;
    if (len_err === 1'b1) lenerr_cnt++;
    if (busy === 1'b1 && s_ar_ready !== '0) busy_ready_cnt++;
    for (int m = 0; m < NM; m++) begin
      if (s_r_valid[m] === 1'b1 && s_r_ready[m] === 1'b1) beats_to[m]++;
      if (reset === 1'b1 && s_ar_valid[m] === 1'b1 && s_ar_ready[m] === 1'b1) grants.push_back(m);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  function automatic logic [AR_W-1:0] mk_ar(input logic [AW-1:0] a, input logic [7:0] l);
    return {a, l, 3'd4, 2'd1};
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Round robin as stated: first requester found after the last owner, wrapping
  function automatic int rr_next(input logic [NM-1:0] req, input int last);
    for (int k = 1; k <= NM; k++)
      if (req[(last + k) % NM]) return (last + k) % NM;
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic issue(input int m, input logic [AW-1:0] addr, input logic [7:0] len, output int tmo);
    int waited = 0;
    @(negedge clk);
    s_ar_valid[m] = 1'b1;
    s_ar_payload[m*AR_W +: AR_W] = mk_ar(addr, len);
    #1;
    while (s_ar_ready[m] !== 1'b1 && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    tmo = (s_ar_ready[m] !== 1'b1) ? 1 : 0;
    @(negedge clk);
    s_ar_valid[m] = 1'b0;
  endtask

  // Plays the RAM for one burst: accepts AR, then returns nbeats beats (last on the final one)
  task automatic ram_serve(input int nbeats, input int owner, input int stall_at, input int stall_n,
                           input int abort_at, output int data_bad, output int ctl_bad,
                           output int stall_seen, output int tmo);
    logic [R_W-1:0] beat;
    int b = 0;
    int st = 0;
    int waited = 0;
    data_bad = 0; ctl_bad = 0; stall_seen = 0; tmo = 0;
    @(negedge clk);
    while (m_ar_valid !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (m_ar_valid !== 1'b1) begin
      tmo = 1;
      return;
    end
    m_ar_ready = 1'b1;
    @(negedge clk);
    m_ar_ready = 1'b0;
    beat = {rnd128(), 2'b00, (nbeats == 1)};
    waited = 0;
    while (b < nbeats && waited < 4000) begin
      m_r_valid   = 1'b1;
      m_r_payload = beat;
      s_r_ready[owner] = !(b == stall_at && st < stall_n);
      if (b == abort_at) return;
      #1;
      if (s_r_payload !== beat) data_bad++;
      if (s_r_valid !== (NM'(1) << owner) || m_r_ready !== s_r_ready[owner]) ctl_bad++;
      if (m_r_ready === 1'b0) stall_seen++;
      @(negedge clk);
      waited++;
      if (s_r_ready[owner]) begin
        b++;
        beat = {rnd128(), 2'b00, (b == nbeats - 1)};
      end else begin
        st++;
      end
    end
    if (b < nbeats) tmo = 1;
    m_r_valid = 1'b0;
    s_r_ready[owner] = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; s_ar_valid = '0; s_ar_payload = '0; s_r_ready = '1;
    m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_payload = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (m_ar_valid !== 1'b0) $display("FAIL reset_m_ar_valid: got %b expected 0", m_ar_valid); else n_pass++;
    n_checks++; if (m_ar_payload !== '0) $display("FAIL reset_m_ar_payload: got %h expected 0", m_ar_payload); else n_pass++;
    n_checks++; if (grant_id !== GW'(NM-1)) $display("FAIL reset_grant_id: got %0d expected %0d", grant_id, NM-1); else n_pass++;
    n_checks++; if (busy !== 1'b0 || len_err !== 1'b0) $display("FAIL reset_busy_len_err: got %b%b expected 00", busy, len_err); else n_pass++;
    n_checks++; if (s_ar_ready !== '0 || s_r_valid !== '0 || m_r_ready !== 1'b0)
      $display("FAIL reset_comb_outputs: got %b/%b/%b expected 0/0/0", s_ar_ready, s_r_valid, m_r_ready); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    int tmo, db, cb, ss, b0, b1, le;
    issue(0, 32'h100, 8'd3, tmo);
    #1;
    n_checks++; if (tmo !== 0 || m_ar_valid !== 1'b1) $display("FAIL single_ar: got tmo=%0d m_ar_valid=%b expected 0/1", tmo, m_ar_valid); else n_pass++;
    n_checks++; if (m_ar_payload[AR_W-1:13] !== 32'h100) $display("FAIL single_addr: got %h expected 100", m_ar_payload[AR_W-1:13]); else n_pass++;
    n_checks++; if (m_ar_payload[12:5] !== 8'd3) $display("FAIL single_len: got %0d expected 3", m_ar_payload[12:5]); else n_pass++;
    b0 = beats_to[0]; b1 = beats_to[1]; le = lenerr_cnt;
    ram_serve(4, 0, -1, 0, -1, db, cb, ss, tmo);
    #3;
    n_checks++; if (beats_to[0] - b0 !== 4) $display("FAIL single_beats_m0: got %0d expected 4", beats_to[0] - b0); else n_pass++;
    n_checks++; if (beats_to[1] - b1 !== 0) $display("FAIL single_beats_m1: got %0d expected 0", beats_to[1] - b1); else n_pass++;
    n_checks++; if (lenerr_cnt - le !== 0) $display("FAIL single_len_err: got %0d expected 0", lenerr_cnt - le); else n_pass++;
    n_checks++; if (db + cb + tmo !== 0 || busy !== 1'b0) $display("FAIL single_ctl: got bad=%0d busy=%b expected 0/0", db + cb + tmo, busy); else n_pass++;
  endtask

  task automatic test_rotation();
    int exp_seq[6];
    int last, g0, bad, db, cb, ss, tmo;
    apply_reset();
    @(negedge clk);
    s_ar_payload[0*AR_W +: AR_W] = mk_ar(32'hA000, 8'd0);
    s_ar_payload[1*AR_W +: AR_W] = mk_ar(32'hB000, 8'd0);
    s_ar_valid = '1;
    g0 = grants.size(); last = NM - 1; bad = 0;
    for (int r = 0; r < 6; r++) begin
      exp_seq[r] = rr_next('1, last);
      ram_serve(1, exp_seq[r], -1, 0, -1, db, cb, ss, tmo);
      bad += db + cb + tmo;
      last = exp_seq[r];
    end
    s_ar_valid = '0;
    #3;
    for (int r = 0; r < 6; r++) begin
      n_checks++;
      if (grants.size() <= g0 + r) $display("FAIL rotation_grant_%0d: got none expected %0d", r, exp_seq[r]);
      else if (grants[g0 + r] !== exp_seq[r]) $display("FAIL rotation_grant_%0d: got %0d expected %0d", r, grants[g0 + r], exp_seq[r]);
      else n_pass++;
    end
    n_checks++; if (bad !== 0) $display("FAIL rotation_beats: got %0d bad expected 0", bad); else n_pass++;
  endtask

  task automatic test_backpressure();
    int tmo, db, cb, ss, b1, le;
    issue(1, 32'h4000, 8'd7, tmo);
    b1 = beats_to[1]; le = lenerr_cnt;
    ram_serve(8, 1, 3, 5, -1, db, cb, ss, tmo);
    #3;
    n_checks++; if (ss !== 5) $display("FAIL bp_stall_cycles: got %0d expected 5", ss); else n_pass++;
    n_checks++; if (db + cb + tmo !== 0) $display("FAIL bp_data_ctl: got %0d bad expected 0", db + cb + tmo); else n_pass++;
    n_checks++; if (beats_to[1] - b1 !== 8 || lenerr_cnt - le !== 0)
      $display("FAIL bp_beats: got beats=%0d errs=%0d expected 8/0", beats_to[1] - b1, lenerr_cnt - le); else n_pass++;
  endtask

  task automatic test_hold_request();
    int tmo, db, cb, ss, br;
    br = busy_ready_cnt;
    issue(0, 32'h300, 8'd3, tmo);
    s_ar_payload[1*AR_W +: AR_W] = mk_ar(32'h2000, 8'd0);
    s_ar_valid[1] = 1'b1;
    ram_serve(4, 0, 1, 2, -1, db, cb, ss, tmo);
    #1;
    n_checks++; if (s_ar_ready !== 2'b10) $display("FAIL hold_ready_after_last: got %b expected 10", s_ar_ready); else n_pass++;
    n_checks++; if (busy_ready_cnt - br !== 0) $display("FAIL hold_no_ready_while_busy: got %0d expected 0", busy_ready_cnt - br); else n_pass++;
    @(negedge clk);
    s_ar_valid[1] = 1'b0;
    #1;
    n_checks++; if (grant_id !== GW'(1) || m_ar_valid !== 1'b1) $display("FAIL hold_grant: got %0d/%b expected 1/1", grant_id, m_ar_valid); else n_pass++;
    n_checks++; if (m_ar_payload !== mk_ar(32'h2000, 8'd0)) $display("FAIL hold_payload: got %h expected %h", m_ar_payload, mk_ar(32'h2000, 8'd0)); else n_pass++;
    ram_serve(1, 1, -1, 0, -1, db, cb, ss, tmo);
    n_checks++; if (db + cb + tmo !== 0) $display("FAIL hold_second_burst: got %0d bad expected 0", db + cb + tmo); else n_pass++;
  endtask

  task automatic test_len_err();
    int tmo, db, cb, ss, le;
    le = lenerr_cnt;
    issue(0, 32'h500, 8'd3, tmo);
    ram_serve(2, 0, -1, 0, -1, db, cb, ss, tmo);
    #3;
    n_checks++; if (lenerr_cnt - le !== 1) $display("FAIL short_len_err_pulses: got %0d expected 1", lenerr_cnt - le); else n_pass++;
    n_checks++; if (busy !== 1'b0 || tmo !== 0) $display("FAIL short_idle: got busy=%b tmo=%0d expected 0/0", busy, tmo); else n_pass++;
    issue(1, 32'h600, 8'd0, tmo);
    n_checks++; if (tmo !== 0) $display("FAIL short_next_grant: got tmo=%0d expected 0", tmo); else n_pass++;
    ram_serve(1, 1, -1, 0, -1, db, cb, ss, tmo);
  endtask

  task automatic test_boundary_len();
    int tmo, db, cb, ss, b0, b1, le;
    b1 = beats_to[1]; le = lenerr_cnt;
    issue(1, 32'h7000, 8'd255, tmo);
    ram_serve(256, 1, -1, 0, -1, db, cb, ss, tmo);
    #3;
    n_checks++; if (beats_to[1] - b1 !== 256 || lenerr_cnt - le !== 0 || db + cb + tmo !== 0)
      $display("FAIL len255: got beats=%0d errs=%0d bad=%0d expected 256/0/0", beats_to[1] - b1, lenerr_cnt - le, db + cb + tmo); else n_pass++;
    b0 = beats_to[0]; le = lenerr_cnt;
    issue(0, 32'h7100, 8'd0, tmo);
    ram_serve(1, 0, -1, 0, -1, db, cb, ss, tmo);
    #3;
    n_checks++; if (beats_to[0] - b0 !== 1 || lenerr_cnt - le !== 0)
      $display("FAIL len0: got beats=%0d errs=%0d expected 1/0", beats_to[0] - b0, lenerr_cnt - le); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int tmo, db, cb, ss;
    issue(0, 32'h800, 8'd7, tmo);
    ram_serve(8, 0, -1, 0, 2, db, cb, ss, tmo);
    reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || m_ar_valid !== 1'b0) $display("FAIL rstmid_busy_arv: got %b/%b expected 0/0", busy, m_ar_valid); else n_pass++;
    n_checks++; if (s_r_valid !== '0 || m_r_ready !== 1'b0) $display("FAIL rstmid_r: got %b/%b expected 0/0", s_r_valid, m_r_ready); else n_pass++;
    n_checks++; if (grant_id !== GW'(NM-1)) $display("FAIL rstmid_grant_id: got %0d expected %0d", grant_id, NM-1); else n_pass++;
    m_r_valid = 1'b0;
    s_r_ready = '1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    s_ar_valid = '1;
    #1;
    n_checks++; if (s_ar_ready !== 2'b01) $display("FAIL rstmid_first_grant: got %b expected 01", s_ar_ready); else n_pass++;
    s_ar_valid = '0;
  endtask

  task automatic test_random();
    logic [NM-1:0] pend = '0;
    logic [AW-1:0] paddr[NM];
    int plen[NM];
    int last, w, nb, exp_err, bw, le, db, cb, ss, tmo, sa;
    int deltas[6] = '{-1, 0, 0, 0, 1, 2};
    apply_reset();
    @(negedge clk);
    last = NM - 1;
    for (int r = 0; r < 20; r++) begin
      for (int m = 0; m < NM; m++) begin
        if (!pend[m] && ($urandom_range(0, 2) != 0 || (pend == '0 && m == NM - 1))) begin
          pend[m]  = 1'b1;
          paddr[m] = $urandom;
          plen[m]  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(16, 40)) : int'($urandom_range(0, 6));
          s_ar_payload[m*AR_W +: AR_W] = mk_ar(paddr[m], 8'(plen[m]));
        end
      end
      s_ar_valid = pend;
      #1;
      w = rr_next(pend, last);
      n_checks++; if (s_ar_ready !== (NM'(1) << w)) $display("FAIL rand%0d_ar_ready: got %b expected %b", r, s_ar_ready, NM'(1) << w); else n_pass++;
      @(negedge clk);
      pend[w] = 1'b0;
      s_ar_valid = pend;
      #1;
      n_checks++; if (grant_id !== GW'(w) || m_ar_payload !== mk_ar(paddr[w], 8'(plen[w])))
        $display("FAIL rand%0d_ar: got id=%0d %h expected id=%0d %h", r, grant_id, m_ar_payload, w, mk_ar(paddr[w], 8'(plen[w]))); else n_pass++;
      last = w;
      nb = plen[w] + 1 + deltas[$urandom_range(0, 5)];
      if (nb < 1) nb = 1;
      exp_err = (nb < plen[w] + 1) ? 1 : nb - (plen[w] + 1);
      sa = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, nb - 1));
      bw = beats_to[w]; le = lenerr_cnt;
      ram_serve(nb, w, sa, $urandom_range(1, 3), -1, db, cb, ss, tmo);
      #3;
      n_checks++; if (beats_to[w] - bw !== nb || db + cb + tmo !== 0)
        $display("FAIL rand%0d_beats: got %0d bad=%0d expected %0d bad=0", r, beats_to[w] - bw, db + cb + tmo, nb); else n_pass++;
      n_checks++; if (lenerr_cnt - le !== exp_err) $display("FAIL rand%0d_len_err: got %0d expected %0d", r, lenerr_cnt - le, exp_err); else n_pass++;
    end
    s_ar_valid = '0;
    n_checks++; if (busy_ready_cnt !== 0) $display("FAIL ar_ready_while_busy: got %0d cycles expected 0", busy_ready_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_hold_request();
    test_len_err();
    test_boundary_len();
    test_reset_mid_burst();
    test_random();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
